// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add significand product, truncating normalise.
// Define FP_MUL_SPECIAL_EN to add NaN/infinity operand handling.
module fp_mul_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [DATA_WIDTH-1:0] out_result
);

    localparam int unsigned SigW     = MANT_WIDTH + 1;
    localparam int unsigned ProdW    = 2 * SigW;
    localparam int unsigned ExpCalcW = EXP_WIDTH + 2;

    localparam logic signed [ExpCalcW-1:0] Bias    = ExpCalcW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic signed [ExpCalcW-1:0] ExpMax  = ExpCalcW'((2 ** EXP_WIDTH) - 1);
    localparam logic signed [ExpCalcW-1:0] ExpZero = '0;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e                       state_q;
    logic [4:0]                   cnt_q;
    logic [ProdW-1:0]             prod_q;
    logic [SigW-1:0]              mcand_q;
    logic signed [ExpCalcW-1:0]   exp_q;
    logic                         sign_q;
    logic                         zero_q;
`ifdef FP_MUL_SPECIAL_EN
    logic                         nan_q;
    logic                         inf_q;
`endif

    logic                  sign_a, sign_b;
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [MANT_WIDTH-1:0] mant_a, mant_b;

    assign sign_a = in_numA[DATA_WIDTH-1];
    assign sign_b = in_numB[DATA_WIDTH-1];
    assign exp_a  = in_numA[DATA_WIDTH-2 -: EXP_WIDTH];
    assign exp_b  = in_numB[DATA_WIDTH-2 -: EXP_WIDTH];
    assign mant_a = in_numA[MANT_WIDTH-1:0];
    assign mant_b = in_numB[MANT_WIDTH-1:0];

`ifdef FP_MUL_SPECIAL_EN
    logic nan_a, nan_b, inf_a, inf_b;
    assign nan_a = (&exp_a) && (|mant_a);
    assign nan_b = (&exp_b) && (|mant_b);
    assign inf_a = (&exp_a) && !(|mant_a);
    assign inf_b = (&exp_b) && !(|mant_b);
`endif

    logic signed [ExpCalcW-1:0] exp_sum;
    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - Bias;

    // Upper half accumulates the multiplicand, lower half holds the multiplier and shifts out.
    logic [SigW:0]    step_sum;
    logic [ProdW-1:0] prod_step;
    assign step_sum  = {1'b0, prod_q[ProdW-1:SigW]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {step_sum, prod_q[SigW-1:1]};

    logic signed [ExpCalcW-1:0] exp_fin;
    logic [MANT_WIDTH-1:0]      mant_norm;
    assign exp_fin   = exp_q + $signed({{(ExpCalcW - 1){1'b0}}, prod_q[ProdW-1]});
    assign mant_norm = prod_q[ProdW-1] ? prod_q[ProdW-2 -: MANT_WIDTH]
                                       : prod_q[ProdW-3 -: MANT_WIDTH];

    logic                  res_sign;
    logic [EXP_WIDTH-1:0]  res_exp;
    logic [MANT_WIDTH-1:0] res_mant;

    always_comb begin
        res_sign = sign_q;
        res_exp  = '0;
        res_mant = '0;
`ifdef FP_MUL_SPECIAL_EN
        if (nan_q) begin
            res_sign = 1'b0;
            res_exp  = '1;
            res_mant = {1'b1, {(MANT_WIDTH - 1){1'b0}}};
        end else if (inf_q) begin
            res_exp = '1;
        end else
`endif
        if (zero_q) begin
            res_exp = '0;
        end else if (exp_fin >= ExpMax) begin
            res_exp = '1;
        end else if (exp_fin <= ExpZero) begin
            res_exp = '0;
        end else begin
            res_exp  = exp_fin[EXP_WIDTH-1:0];
            res_mant = mant_norm;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
`ifdef FP_MUL_SPECIAL_EN
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
`endif
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
            out_result <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    out_done <= 1'b0;
                    if (in_start) begin
                        prod_q   <= {{SigW{1'b0}}, 1'b1, mant_b};
                        mcand_q  <= {1'b1, mant_a};
                        cnt_q    <= 5'(SigW - 1);
                        exp_q    <= exp_sum;
                        sign_q   <= sign_a ^ sign_b;
                        zero_q   <= (exp_a == '0) || (exp_b == '0);
`ifdef FP_MUL_SPECIAL_EN
                        nan_q    <= nan_a || nan_b || (inf_a && exp_b == '0)
                                    || (inf_b && exp_a == '0);
                        inf_q    <= inf_a || inf_b;
`endif
                        out_busy <= 1'b1;
                        state_q  <= StMul;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    prod_q <= prod_step;
                    if (cnt_q == 5'd0) begin
                        state_q <= StNorm;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StNorm: begin
                    out_result <= {res_sign, res_exp, res_mant};
                    out_busy   <= 1'b0;
                    out_done   <= 1'b1;
                    state_q    <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: arithmetic reference model with per-cycle compare plus literal vectors.
// Special-value vectors are selected by FP_MUL_SPECIAL_EN, matching the DUT build.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    logic        m_busy    = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;
    int          rem       = 0;
    bit          chk_en    = 1'b0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_start  (start),
        .in_numA   (a),
        .in_numB   (b),
        .out_busy  (busy),
        .out_done  (done),
        .out_result(result)
    );

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        longint      mx, my, p;
        logic [22:0] m;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
`ifdef FP_MUL_SPECIAL_EN
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)
            || (ex == 255 && ey == 0) || (ey == 255 && ex == 0))
            return 32'h7FC00000;
        if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
`endif
        if (ex == 0 || ey == 0) return {s, 31'h0};
        mx = longint'({1'b1, x[22:0]});
        my = longint'({1'b1, y[22:0]});
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (longint'(1) << 47)) begin
            e = e + 1;
            m = 23'(p >> 24);
        end else begin
            m = 23'(p >> 23);
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), m};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference timing: an accepted start makes the result due 25 edges later.
    always @(posedge clk) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_result = '0;
            rem      = 0;
        end else if (rem == 0) begin
            m_done = 1'b0;
            if (start) begin
                rem       = 25;
                m_busy    = 1'b1;
                m_pending = ref_mul(a, b);
            end
        end else begin
            rem = rem - 1;
            if (rem == 0) begin
                m_busy   = 1'b0;
                m_done   = 1'b1;
                m_result = m_pending;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy", {31'b0, busy}, {31'b0, m_busy});
            check32("done", {31'b0, done}, {31'b0, m_done});
            check32("result", result, m_result);
        end
    end

    // Caller sits at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] lit, input int repulse_at);
        int n;
        check32({name, " model"}, ref_mul(ia, ib), lit);
        a     = ia;
        b     = ib;
        start = 1'b1;
        n     = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (repulse_at != 0 && n == repulse_at) begin
                a     = 32'h7F000000;
                b     = 32'h7F000000;
                start = 1'b1;
            end
            if (repulse_at != 0 && n == repulse_at + 1) start = 1'b0;
            if (done) break;
        end
        check32({name, " latency"}, n, 26);
        check32({name, " value"}, result, lit);
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check32("reset busy", {31'b0, busy}, 32'd0);
        check32("reset done", {31'b0, done}, 32'd0);
        check32("reset result", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 0);
        @(negedge clk);
        run_op("-2x3", 32'hC0000000, 32'h40400000, 32'hC0C00000, 0);
        // Started during the DONE cycle of the previous op.
        run_op("-0x1 b2b", 32'h80000000, 32'h3F800000, 32'h80000000, 0);
        @(negedge clk);
        run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 0);
        @(negedge clk);
        run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 0);
        @(negedge clk);
        run_op("repulse", 32'h3FC00000, 32'h40000000, 32'h40400000, 5);
        @(negedge clk);

        // Reset ten cycles into MUL.
        a     = 32'h40400000;
        b     = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check32("mid busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("rst busy", {31'b0, busy}, 32'd0);
        check32("rst done", {31'b0, done}, 32'd0);
        check32("rst result", result, 32'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check32("no done after rst", pulses, 0);

        run_op("3x3", 32'h40400000, 32'h40400000, 32'h41100000, 0);
        @(negedge clk);
`ifdef FP_MUL_SPECIAL_EN
        run_op("inf*0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0);
        @(negedge clk);
        run_op("-inf*2", 32'hFF800000, 32'h40000000, 32'hFF800000, 0);
        @(negedge clk);
        run_op("nan*1", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0);
`else
        run_op("inf*0 plain", 32'h7F800000, 32'h00000000, 32'h00000000, 0);
        @(negedge clk);
        run_op("-inf*2 plain", 32'hFF800000, 32'h40000000, 32'hFF800000, 0);
        @(negedge clk);
        run_op("nan*1 plain", 32'h7FC00000, 32'h3F800000, 32'h7F800000, 0);
`endif
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
